inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// Generic synchronous FIFO; head entry is presented from registered state.
// Latency: a push is visible at the head on the edge after an empty-FIFO push.
// Backpressure: caller must not push when full or pop when empty.
module fifo #(
  parameter int              WIDTH   = 64,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_DAT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_DAT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_rdy) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_vld, pop_rdy})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// RV32 instruction encoder: packs format fields into a word tagged with its memory address.
// Latency: one cycle from input acceptance to out_valid through a 2-entry FIFO.
// Backpressure: in_ready drops when both FIFO entries are occupied; out_ready never reaches in_ready.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          MEM_DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [1:0]  err_flags,
  output logic [31:0] enc_count
);
  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_DEPTH_WORDS - 1));

  logic        acc_vld, pop_rdy, fifo_empty, fifo_full;
  logic [31:0] enc_dat, wr_addr;
  logic        imm_bad, fmt_bad;

  // Reset gates in_ready so nothing is offered while the FIFO is being cleared.
  assign in_ready  = !rst && !fifo_full;
  assign out_valid = !fifo_empty;
  assign acc_vld   = in_valid && in_ready;
  assign pop_rdy   = out_valid && out_ready;

  always_comb begin
    enc_dat = NOP;
    imm_bad = 1'b0;
    fmt_bad = 1'b0;
    case (fmt)
      FMT_R: enc_dat = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: begin
        enc_dat = {imm[11:0], rs1, func3, rd, opcode};
        imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_S: begin
        enc_dat = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
        imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        enc_dat = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      FMT_U: begin
        enc_dat = {imm[31:12], rd, opcode};
        imm_bad = |imm[11:0];
      end
      FMT_J: begin
        enc_dat = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      default: fmt_bad = 1'b1;
    endcase
  end

  fifo #(
    .WIDTH   (64),
    .DEPTH   (2),
    .RST_DAT ({32'h0, BASE_ADDR})
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (acc_vld),
    .push_dat ({enc_dat, wr_addr}),
    .pop_rdy  (pop_rdy),
    .head_dat ({out_instr, out_addr}),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr   <= BASE_ADDR;
      err_flags <= 2'b00;
      enc_count <= '0;
    end else begin
      if (acc_vld) begin
        wr_addr   <= (wr_addr == LAST_ADDR) ? BASE_ADDR : wr_addr + 32'd4;
        err_flags <= err_flags | {fmt_bad, imm_bad};
      end
      if (pop_rdy && enc_count != 32'hFFFF_FFFF) enc_count <= enc_count + 32'd1;
    end
  end
endmodule
